range_updater_iter: RTL and testbench



---
 rtl/range_calc_pkg.sv | 26 ++
 rtl/range_seq_div.sv | 74 +++++++
 rtl/range_updater_iter.sv | 199 +++++++++++++++++++
 tb/tb_range_updater_iter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/range_calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | range_calc_pkg : shared types and constants for the range-update unit      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package range_calc_pkg;

  localparam int RC_W       = 16;
  localparam int RC_LATENCY = 2 * RC_W + 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_LO = 3'd1,
    DIV_LO = 3'd2,
    MUL_HI = 3'd3,
    DIV_HI = 3'd4,
    NORM   = 3'd5,
    DONE   = 3'd6
  } state_e;

  function automatic int calc_latency(input int w);
    return 2 * w + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/range_seq_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | range_seq_div : W-iteration restoring divider, 2W/W -> W quotient, MSB 1st |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module range_seq_div #(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [2*W-1:0] dividend_i,
  input  logic [W-1:0]   divisor_i,
  output logic           done_o,
  output logic [W-1:0]   quot_o
);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [W:0]       w_trial;
  logic             w_ge;
  logic [W-1:0]     w_rem_next;

  // quo_q shifts dividend bits out of its MSB and quotient bits into its LSB
  assign w_trial    = {rem_q, quo_q[W-1]};
  assign w_ge       = (w_trial >= {1'b0, div_q});
  assign w_rem_next = w_ge ? W'(w_trial - {1'b0, div_q}) : W'(w_trial);

  assign done_o = busy_q && (cnt_q == CNT_W'(W - 1));
  assign quot_o = {quo_q[W-2:0], w_ge};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = dividend_i[2*W-1:W];
      quo_d  = dividend_i[W-1:0];
      div_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = w_rem_next;
      quo_d = {quo_q[W-2:0], w_ge};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(W - 1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/range_updater_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | range_updater_iter : iterative range update, low_off=r*lo/t, range=r*hi/t- |
// | low_off. Optional renormalisation via RANGE_RENORM_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
module range_updater_iter
  import range_calc_pkg::*;
#(
  parameter int W     = RC_W,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     range_in,
  input  logic [W-1:0]     cum_lo,
  input  logic [W-1:0]     cum_hi,
  input  logic [W-1:0]     total,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     range_out,
  output logic [W-1:0]     low_off,
  output logic             err_flag,
  output logic             busy
`ifdef RANGE_RENORM_EN
  , output logic [CNT_W-1:0] norm_shift
`endif
);

  state_e       state_q, state_d;
  logic [W-1:0] range_q, range_d;
  logic [W-1:0] clo_q, clo_d;
  logic [W-1:0] chi_q, chi_d;
  logic [W-1:0] tot_q, tot_d;
  logic [W-1:0] qlo_q, qlo_d;
  logic [W-1:0] rout_q, rout_d;
  logic [W-1:0] loff_q, loff_d;
  logic         err_q, err_d;

  logic           w_start;
  logic           w_div_done;
  logic [W-1:0]   w_quot;
  logic [2*W-1:0] w_prod;
  logic           w_bad;

`ifdef RANGE_RENORM_EN
  logic [W-1:0]     qhi_q, qhi_d;
  logic [CNT_W-1:0] nsh_q, nsh_d;
  logic [W-1:0]     w_diff;
  logic [CNT_W-1:0] w_lz;

  assign w_diff     = qhi_q - qlo_q;
  assign norm_shift = nsh_q;

  // Last matching iteration is the highest set bit, giving the leading-zero count
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < W; i++) begin
      if (w_diff[i]) w_lz = CNT_W'(W - 1 - i);
    end
  end
`endif

  assign w_prod = (2*W)'(range_q) * (2*W)'((state_q == MUL_HI) ? chi_q : clo_q);
  assign w_bad  = (total == '0) || (cum_lo >= cum_hi) || (cum_hi > total);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign range_out = rout_q;
  assign low_off   = loff_q;
  assign err_flag  = err_q;

  range_seq_div #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (w_start),
    .dividend_i (w_prod),
    .divisor_i  (tot_q),
    .done_o     (w_div_done),
    .quot_o     (w_quot)
  );

  always_comb begin
    state_d = state_q;
    range_d = range_q;
    clo_d   = clo_q;
    chi_d   = chi_q;
    tot_d   = tot_q;
    qlo_d   = qlo_q;
    rout_d  = rout_q;
    loff_d  = loff_q;
    err_d   = err_q;
    w_start = 1'b0;
`ifdef RANGE_RENORM_EN
    qhi_d   = qhi_q;
    nsh_d   = nsh_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          range_d = range_in;
          clo_d   = cum_lo;
          chi_d   = cum_hi;
          tot_d   = total;
          if (w_bad) begin
            rout_d  = range_in;
            loff_d  = '0;
            err_d   = 1'b1;
`ifdef RANGE_RENORM_EN
            nsh_d   = '0;
`endif
            state_d = DONE;
          end else begin
            state_d = MUL_LO;
          end
        end
      end
      MUL_LO: begin
        w_start = 1'b1;
        state_d = DIV_LO;
      end
      DIV_LO: begin
        if (w_div_done) begin
          qlo_d   = w_quot;
          state_d = MUL_HI;
        end
      end
      MUL_HI: begin
        w_start = 1'b1;
        state_d = DIV_HI;
      end
      DIV_HI: begin
        if (w_div_done) begin
`ifdef RANGE_RENORM_EN
          qhi_d   = w_quot;
          state_d = NORM;
`else
          rout_d  = w_quot - qlo_q;
          loff_d  = qlo_q;
          err_d   = 1'b0;
          state_d = DONE;
`endif
        end
      end
`ifdef RANGE_RENORM_EN
      NORM: begin
        loff_d  = qlo_q;
        rout_d  = w_diff << w_lz;
        nsh_d   = (w_diff == '0) ? '0 : w_lz;
        err_d   = (w_diff == '0);
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      range_q <= '0;
      clo_q   <= '0;
      chi_q   <= '0;
      tot_q   <= '0;
      qlo_q   <= '0;
      rout_q  <= '0;
      loff_q  <= '0;
      err_q   <= 1'b0;
`ifdef RANGE_RENORM_EN
      qhi_q   <= '0;
      nsh_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      range_q <= range_d;
      clo_q   <= clo_d;
      chi_q   <= chi_d;
      tot_q   <= tot_d;
      qlo_q   <= qlo_d;
      rout_q  <= rout_d;
      loff_q  <= loff_d;
      err_q   <= err_d;
`ifdef RANGE_RENORM_EN
      qhi_q   <= qhi_d;
      nsh_q   <= nsh_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_range_updater_iter.sv
`default_nettype none
// Bench for range_updater_iter: directed and random operand sets against an
// arithmetic reference model, with backpressure and mid-operation reset.
module tb_range_updater_iter;

  localparam int W     = 16;
  localparam int CNT_W = $clog2(W + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] range_in, cum_lo, cum_hi, total;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] range_out, low_off;
  logic         err_flag;
  logic         busy;
`ifdef RANGE_RENORM_EN
  logic [CNT_W-1:0] norm_shift;
  localparam int LAT = 2 * W + 4;
`else
  localparam int LAT = 2 * W + 3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  range_updater_iter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .range_in  (range_in),
    .cum_lo    (cum_lo),
    .cum_hi    (cum_hi),
    .total     (total),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .range_out (range_out),
    .low_off   (low_off),
    .err_flag  (err_flag),
    .busy      (busy)
`ifdef RANGE_RENORM_EN
    , .norm_shift (norm_shift)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic straight from the interval definition
  task automatic model(input longint r, cl, ch, t,
                       output logic [W-1:0] ro, lo, output logic e,
                       output int ns, output int lat);
    longint a, b, d;
    ns = 0;
    if (t == 0 || cl >= ch || ch > t) begin
      ro = W'(r); lo = '0; e = 1'b1; lat = 1;
    end else begin
      a = (r * cl) / t;
      b = (r * ch) / t;
      d = b - a;
      lo = W'(a); e = 1'b0; lat = LAT;
`ifdef RANGE_RENORM_EN
      if (d == 0) e = 1'b1;
      else while (d < (longint'(1) << (W - 1))) begin d = d * 2; ns++; end
`endif
      ro = W'(d);
    end
  endtask

  task automatic run_txn(input logic [W-1:0] r, cl, ch, t, input int bp);
    logic [W-1:0] ero, elo;
    logic         ee;
    int           ens, elat, n;
    model(r, cl, ch, t, ero, elo, ee, ens, elat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    range_in = r; cum_lo = cl; cum_hi = ch; total = t; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      // Operand noise while busy must be ignored
      in_valid = 1'($urandom);
      range_in = W'($urandom); cum_lo = W'($urandom); cum_hi = W'($urandom); total = W'($urandom);
    end while (!out_valid && n < 200);
    chk("latency", n, elat);
    chk("range_out", range_out, ero);
    chk("low_off", low_off, elo);
    chk("err_flag", err_flag, ee);
`ifdef RANGE_RENORM_EN
    chk("norm_shift", norm_shift, ens);
`endif
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_range", range_out, ero);
      chk("bp_low", low_off, elo);
      chk("bp_err", err_flag, ee);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] rt, tt, ht, lt;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    range_in = '0; cum_lo = '0; cum_hi = '0; total = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_range", range_out, 0);
    chk("rst_low", low_off, 0);
    reset = 1'b0;

    run_txn(16'h8000, 16'h0400, 16'h0C00, 16'h1000, 0);
    run_txn(16'hFFFF, 16'h0001, 16'h0003, 16'h0007, 0);
    run_txn(16'h1234, 16'h0001, 16'h0002, 16'h0000, 0);
    run_txn(16'h4321, 16'h0005, 16'h0005, 16'h0010, 0);
    run_txn(16'hABCD, 16'h0002, 16'h0011, 16'h0010, 0);
    run_txn(16'hBEEF, 16'h0003, 16'h0010, 16'h0010, 0);
    run_txn(16'h0001, 16'h0001, 16'h0002, 16'h0010, 0);
    run_txn(16'h9000, 16'h0010, 16'h0300, 16'h0400, 10);
    run_txn(16'h7777, 16'h0000, 16'hFFFF, 16'hFFFF, 2);

    // Abort mid-operation and confirm a clean restart
    @(negedge clk);
    range_in = 16'h8000; cum_lo = 16'h0400; cum_hi = 16'h0C00; total = 16'h1000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_range", range_out, 0);
    chk("mid_rst_low", low_off, 0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(16'h8000, 16'h0400, 16'h0C00, 16'h1000, 0);

    for (int i = 0; i < 16; i++) begin
      tt = W'($urandom_range(1, 65535));
      ht = W'($urandom_range(1, int'(tt)));
      lt = W'($urandom_range(0, int'(ht) - 1));
      rt = W'($urandom);
      if ($urandom_range(0, 4) == 0) lt = ht;
      run_txn(rt, lt, ht, tt, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
